// File: rtl/spi_ram_pkg.sv
// Shared constants and types for the SPI serial-SRAM responder.
// Holds the opcode set, the mode-register encodings and the FSM state enum.
package spi_ram_pkg;

    // Serial-SRAM opcodes
    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_RDSR  = 8'h05;
    localparam logic [7:0] CMD_WRSR  = 8'h01;

    // mode[7:6] encodings; 2'b11 behaves as sequential
    localparam logic [1:0] MODE_BYTE = 2'b00;
    localparam logic [1:0] MODE_PAGE = 2'b10;
    localparam logic [1:0] MODE_SEQ  = 2'b01;
    localparam logic [1:0] MODE_RST  = MODE_SEQ;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_READ,
        ST_WRITE,
        ST_RDSR,
        ST_WRSR,
        ST_IGNORE
    } spi_resp_state_t;

    // Full status byte as seen on the wire: only bits [7:6] are implemented
    function automatic logic [7:0] mode_to_byte(input logic [1:0] m);
        return {m, 6'b0};
    endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Input register / synchroniser for one SPI pin with rise/fall pulse outputs.
// With SPI_RAM_RESP_SYNC_EN defined a 2-FF synchroniser precedes the edge
// detector (asynchronous master); otherwise a single register stage is used
// and the master must run on clk.
module spi_edge_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic sync_q;
    logic prev_q;

`ifdef SPI_RAM_RESP_SYNC_EN
    logic meta_q;

    // Two-flop synchroniser followed by a delayed copy for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
            prev_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end
`else
    // Single sampling register followed by a delayed copy for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= RST_VAL;
            prev_q <= RST_VAL;
        end else begin
            sync_q <= d_i;
            prev_q <= sync_q;
        end
    end
`endif

    assign q_o    = sync_q;
    assign rise_o = sync_q & ~prev_q;
    assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/spi_ram_responder.sv
// SPI-slave (mode 0) serial-SRAM responder backed by an internal byte array.
// Decodes READ/WRITE/RDSR/WRSR with 24-bit addresses; only the low ADDR_BITS
// address bits are kept. Optional macro SPI_RAM_RESP_SYNC_EN inserts 2-FF
// synchronisers on the pins (see spi_edge_sync).
module spi_ram_responder
    import spi_ram_pkg::*;
#(
    parameter int ADDR_BITS  = 8,
    parameter int PAGE_BYTES = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic SCK,
    input  logic CS_N,
    input  logic MOSI,
    output logic MISO,
    output logic MISO_OE,
    output logic busy,
    output logic cmd_err
);

    localparam int MEM_BYTES = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS-1:0] PAGE_MASK = ADDR_BITS'(PAGE_BYTES - 1);

    // Pin conditioning
    logic sck_rise, sck_fall, sck_lvl_unused;
    logic cs_lvl, cs_rise_unused, cs_fall_unused;
    logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;

    spi_edge_sync #(.RST_VAL(1'b0)) u_sck (
        .clk(clk), .reset(reset), .d_i(SCK),
        .q_o(sck_lvl_unused), .rise_o(sck_rise), .fall_o(sck_fall)
    );

    spi_edge_sync #(.RST_VAL(1'b1)) u_cs (
        .clk(clk), .reset(reset), .d_i(CS_N),
        .q_o(cs_lvl), .rise_o(cs_rise_unused), .fall_o(cs_fall_unused)
    );

    spi_edge_sync #(.RST_VAL(1'b0)) u_mosi (
        .clk(clk), .reset(reset), .d_i(MOSI),
        .q_o(mosi_lvl), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
    );

    // State
    spi_resp_state_t       state_q, state_d;
    logic [4:0]            bit_cnt_q, bit_cnt_d;
    logic [6:0]            rx_q, rx_d;
    logic [ADDR_BITS-1:0]  addr_q, addr_d;
    logic [7:0]            tx_q, tx_d;
    logic                  miso_q, miso_d;
    logic [1:0]            mode_q, mode_d;
    logic                  is_read_q, is_read_d;
    logic                  cmd_err_q, cmd_err_d;
    logic                  busy_q;

    logic [7:0]            mem_q [MEM_BYTES];

    logic [7:0]            rx_byte;
    logic [ADDR_BITS-1:0]  addr_shift;
    logic [ADDR_BITS-1:0]  addr_nxt;
    logic                  last_bit;
    logic                  mem_we;
    logic                  oe;

    // Address advance: page mode wraps inside the aligned page, else whole array
    function automatic logic [ADDR_BITS-1:0] next_addr(
        input logic [ADDR_BITS-1:0] a,
        input logic [1:0]           m
    );
        logic [ADDR_BITS-1:0] inc;
        inc = a + 1'b1;
        if (m == MODE_PAGE) return (a & ~PAGE_MASK) | (inc & PAGE_MASK);
        return inc;
    endfunction

    assign rx_byte    = {rx_q, mosi_lvl};
    assign addr_shift = {addr_q[ADDR_BITS-2:0], mosi_lvl};
    assign addr_nxt   = next_addr(addr_q, mode_q);
    assign last_bit   = (bit_cnt_q[2:0] == 3'd7);
    assign oe         = (state_q == ST_READ) || (state_q == ST_RDSR);

    // Next-state and datapath decode; SCK edges only count once selected
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rx_d      = rx_q;
        addr_d    = addr_q;
        tx_d      = tx_q;
        miso_d    = miso_q;
        mode_d    = mode_q;
        is_read_d = is_read_q;
        cmd_err_d = 1'b0;
        mem_we    = 1'b0;

        if (state_q == ST_IDLE) begin
            bit_cnt_d = 5'd0;
            if (!cs_lvl) state_d = ST_CMD;
        end else begin
            if (sck_rise) begin
                rx_d      = rx_byte[6:0];
                bit_cnt_d = bit_cnt_q + 5'd1;
                case (state_q)
                    ST_CMD: begin
                        if (last_bit) begin
                            bit_cnt_d = 5'd0;
                            case (rx_byte)
                                CMD_READ: begin
                                    state_d   = ST_ADDR;
                                    is_read_d = 1'b1;
                                end
                                CMD_WRITE: begin
                                    state_d   = ST_ADDR;
                                    is_read_d = 1'b0;
                                end
                                CMD_RDSR: begin
                                    state_d = ST_RDSR;
                                    tx_d    = mode_to_byte(mode_q);
                                end
                                CMD_WRSR: state_d = ST_WRSR;
                                default: begin
                                    state_d   = ST_IGNORE;
                                    cmd_err_d = 1'b1;
                                end
                            endcase
                        end
                    end
                    ST_ADDR: begin
                        addr_d = addr_shift;
                        if (bit_cnt_q == 5'd23) begin
                            bit_cnt_d = 5'd0;
                            if (is_read_q) begin
                                state_d = ST_READ;
                                tx_d    = mem_q[addr_shift];
                            end else begin
                                state_d = ST_WRITE;
                            end
                        end
                    end
                    ST_READ: begin
                        if (last_bit) begin
                            bit_cnt_d = 5'd0;
                            addr_d    = addr_nxt;
                            tx_d      = mem_q[addr_nxt];
                            if (mode_q == MODE_BYTE) state_d = ST_IGNORE;
                        end
                    end
                    ST_WRITE: begin
                        if (last_bit) begin
                            bit_cnt_d = 5'd0;
                            mem_we    = 1'b1;
                            addr_d    = addr_nxt;
                            if (mode_q == MODE_BYTE) state_d = ST_IGNORE;
                        end
                    end
                    ST_RDSR: begin
                        if (last_bit) begin
                            bit_cnt_d = 5'd0;
                            tx_d      = mode_to_byte(mode_q);
                        end
                    end
                    ST_WRSR: begin
                        if (last_bit) begin
                            bit_cnt_d = 5'd0;
                            mode_d    = rx_byte[7:6];
                            state_d   = ST_IGNORE;
                        end
                    end
                    default: bit_cnt_d = 5'd0;
                endcase
            end

            // Mode 0: next data bit leaves on the falling edge
            if (sck_fall && oe) begin
                miso_d = tx_q[7];
                tx_d   = {tx_q[6:0], 1'b0};
            end

            // Deselect wins over any decode, but the data side effects above still land
            if (cs_lvl) state_d = ST_IDLE;
        end

        if (!((state_d == ST_READ) || (state_d == ST_RDSR))) miso_d = 1'b0;
    end

    // Control and shift registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= 5'd0;
            rx_q      <= 7'd0;
            addr_q    <= '0;
            tx_q      <= 8'd0;
            miso_q    <= 1'b0;
            mode_q    <= MODE_RST;
            is_read_q <= 1'b0;
            cmd_err_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            rx_q      <= rx_d;
            addr_q    <= addr_d;
            tx_q      <= tx_d;
            miso_q    <= miso_d;
            mode_q    <= mode_d;
            is_read_q <= is_read_d;
            cmd_err_q <= cmd_err_d;
            busy_q    <= ~cs_lvl;
        end
    end

    // Byte array write port; contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[addr_q] <= rx_byte;
    end

    assign MISO_OE = oe;
    assign MISO    = miso_q & oe;
    assign busy    = busy_q;
    assign cmd_err = cmd_err_q;

endmodule

// File: tb/tb_spi_ram_responder.sv
// Directed bench for spi_ram_responder: a mode-0 SPI master task set drives
// transactions and queues expected read bytes; a monitor assembles MISO bytes
// while MISO_OE is high and compares them against the queue.
module tb_spi_ram_responder;
    import spi_ram_pkg::*;

    localparam int HALF = 4;   // clk cycles per SCK phase

    logic clk = 1'b0;
    logic reset, SCK, CS_N, MOSI;
    logic MISO, MISO_OE, busy, cmd_err;

    int errors = 0;
    int checks = 0;
    int err_pulses = 0;
    logic exp_oe = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_sh;
    int mon_bits = 0;

    spi_ram_responder #(.ADDR_BITS(8), .PAGE_BYTES(32)) dut (
        .clk(clk), .reset(reset), .SCK(SCK), .CS_N(CS_N), .MOSI(MOSI),
        .MISO(MISO), .MISO_OE(MISO_OE), .busy(busy), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: OE/idle-MISO checks at every SCK rise; byte scoreboard
    always @(posedge SCK or posedge CS_N) begin
        if (CS_N) begin
            mon_bits = 0;
        end else begin
            check("oe", {31'd0, MISO_OE}, {31'd0, exp_oe});
            if (!MISO_OE) begin
                check("miso_idle", {31'd0, MISO}, 32'd0);
            end else begin
                mon_sh = {mon_sh[6:0], MISO};
                mon_bits++;
                if (mon_bits == 8) begin
                    mon_bits = 0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_byte: got %0h expected none", mon_sh);
                    end else begin
                        check("rd_byte", {24'd0, mon_sh}, {24'd0, exp_q.pop_front()});
                    end
                end
            end
        end
    end

    always @(negedge clk) if (cmd_err === 1'b1) err_pulses++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic clk_wait(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bit(input logic b);
        MOSI = b;
        clk_wait(HALF);
        SCK = 1'b1;
        clk_wait(HALF);
        SCK = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) spi_bit(v[i]);
    endtask

    task automatic cs_begin;
        CS_N = 1'b0;
        clk_wait(HALF);
        check("busy_hi", {31'd0, busy}, 32'd1);
    endtask

    task automatic cs_end;
        exp_oe = 1'b0;
        clk_wait(HALF);
        CS_N = 1'b1;
        clk_wait(3 * HALF);
        check("busy_lo", {31'd0, busy}, 32'd0);
    endtask

    task automatic send_addr(input logic [7:0] cmd, input logic [23:0] a);
        spi_byte(cmd);
        spi_byte(a[23:16]);
        spi_byte(a[15:8]);
        spi_byte(a[7:0]);
    endtask

    task automatic spi_write(input logic [23:0] a, input int n, input logic [7:0] d0, input logic [7:0] d1);
        cs_begin();
        send_addr(CMD_WRITE, a);
        spi_byte(d0);
        if (n > 1) spi_byte(d1);
        cs_end();
    endtask

    task automatic spi_read(input logic [23:0] a, input int n, input logic [7:0] e0, input logic [7:0] e1);
        cs_begin();
        send_addr(CMD_READ, a);
        exp_q.push_back(e0);
        if (n > 1) exp_q.push_back(e1);
        exp_oe = 1'b1;
        for (int i = 0; i < n; i++) spi_byte(8'h00);
        cs_end();
    endtask

    task automatic rdsr(input logic [7:0] e);
        cs_begin();
        spi_byte(CMD_RDSR);
        exp_q.push_back(e);
        exp_q.push_back(e);
        exp_oe = 1'b1;
        spi_byte(8'h00);
        spi_byte(8'h00);
        cs_end();
    endtask

    task automatic wrsr(input logic [7:0] v);
        cs_begin();
        spi_byte(CMD_WRSR);
        spi_byte(v);
        spi_byte(8'hFF);   // extra bits must be ignored
        cs_end();
    endtask

    initial begin
        reset = 1'b1; SCK = 1'b0; CS_N = 1'b1; MOSI = 1'b0;
        clk_wait(3);
        check("rst_miso", {31'd0, MISO}, 32'd0);
        check("rst_oe", {31'd0, MISO_OE}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_cmd_err", {31'd0, cmd_err}, 32'd0);
        reset = 1'b0;
        clk_wait(4);

        // Status after reset
        rdsr(8'h40);

        // Write then read back
        spi_write(24'h000010, 2, 8'hA5, 8'h5A);
        spi_read(24'h000010, 2, 8'hA5, 8'h5A);

        // Sequential wrap at the top of the array
        spi_write(24'h0000FF, 2, 8'h11, 8'h22);
        spi_read(24'h000000, 1, 8'h22, 8'h00);
        spi_read(24'h0000FF, 2, 8'h11, 8'h22);

        // Unknown opcode: one-cycle cmd_err, rest of the frame ignored
        check("no_err_yet", err_pulses, 0);
        cs_begin();
        spi_byte(8'h9F);
        spi_byte(CMD_WRITE);
        spi_byte(8'h00);
        spi_byte(8'h10);
        spi_byte(8'hFF);
        cs_end();
        check("cmd_err_cycles", err_pulses, 1);
        spi_read(24'h000010, 1, 8'hA5, 8'h00);

        // Abort mid-byte leaves the location alone
        spi_write(24'h000005, 1, 8'h3C, 8'h00);
        cs_begin();
        send_addr(CMD_WRITE, 24'h000005);
        for (int i = 0; i < 4; i++) spi_bit(1'b1);
        cs_end();
        spi_read(24'h000005, 1, 8'h3C, 8'h00);

        // Page wrap
        spi_write(24'h000020, 1, 8'h77, 8'h00);
        wrsr(8'h80);
        rdsr(8'h80);
        spi_write(24'h00001F, 2, 8'h33, 8'h44);
        spi_read(24'h000000, 1, 8'h44, 8'h00);
        spi_read(24'h00001F, 1, 8'h33, 8'h00);
        spi_read(24'h000020, 1, 8'h77, 8'h00);

        // Reset in the middle of a read
        cs_begin();
        send_addr(CMD_READ, 24'h000010);
        exp_q.push_back(8'hA5);
        exp_oe = 1'b1;
        spi_byte(8'h00);
        for (int i = 0; i < 3; i++) spi_bit(1'b0);
        @(negedge clk) reset = 1'b1;
        exp_oe = 1'b0;
        @(negedge clk) reset = 1'b0;
        check("mid_rst_oe", {31'd0, MISO_OE}, 32'd0);
        check("mid_rst_miso", {31'd0, MISO}, 32'd0);
        cs_end();
        rdsr(8'h40);
        spi_read(24'h000010, 1, 8'hA5, 8'h00);

        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
